// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER execute stage.
// Holds the ALU operation encoding and the registered execute-result bundle.
package otter_pkg;

    localparam int unsigned XLEN = 32;

    // JALR targets always have bit 0 cleared; every other bit passes through.
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] jal;
        logic [XLEN-1:0] jalr;
        logic [XLEN-1:0] branch;
        logic            br_eq;
        logic            br_lt;
        logic            br_ltu;
    } exec_out_t;

endpackage

// File: rtl/otter_exec_unit_if.sv
// Bundle between the decode pipe register and the execute stage outputs.
// master drives operands and reads results; slave is the execute unit.
interface otter_exec_unit_if
    import otter_pkg::*;
    ;

    logic            EN;
    logic [3:0]      ALU_FUN;
    logic [XLEN-1:0] SRC_A;
    logic [XLEN-1:0] SRC_B;
    logic [XLEN-1:0] RS1;
    logic [XLEN-1:0] RS2;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] I_IMM;
    logic [XLEN-1:0] J_IMM;
    logic [XLEN-1:0] B_IMM;

    logic [XLEN-1:0] RESULT;
    logic [XLEN-1:0] JAL;
    logic [XLEN-1:0] JALR;
    logic [XLEN-1:0] BRANCH;
    logic            BR_EQ;
    logic            BR_LT;
    logic            BR_LTU;

    modport master (
        output EN, ALU_FUN, SRC_A, SRC_B, RS1, RS2, PC, I_IMM, J_IMM, B_IMM,
        input  RESULT, JAL, JALR, BRANCH, BR_EQ, BR_LT, BR_LTU
    );

    modport slave (
        input  EN, ALU_FUN, SRC_A, SRC_B, RS1, RS2, PC, I_IMM, J_IMM, B_IMM,
        output RESULT, JAL, JALR, BRANCH, BR_EQ, BR_LT, BR_LTU
    );

endinterface

// File: rtl/otter_alu_core.sv
// Combinational RV32I ALU: operation select plus two operands to one result.
// Undefined operation codes produce zero.
module otter_alu_core
    import otter_pkg::*;
(
    input  logic [3:0]      alu_fun,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    // Only the low five bits of operand B select the shift distance.
    assign shamt       = src_b[4:0];
    assign lt_signed   = $signed(src_a) < $signed(src_b);
    assign lt_unsigned = src_a < src_b;

    always_comb begin
        result = '0;
        case (alu_fun_t'(alu_fun))
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_SLL:  result = src_a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SRL:  result = src_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
            ALU_OR:   result = src_a | src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_LUI:  result = src_a;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/otter_exec_unit.sv
// OTTER execute stage: ALU, branch address and branch condition generators
// behind a single enable-gated output register.
module otter_exec_unit
    import otter_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    otter_exec_unit_if.slave ex
);

    logic [XLEN-1:0] alu_result;
    exec_out_t       out_next;
    exec_out_t       out_q;

    otter_alu_core u_alu (
        .alu_fun (ex.ALU_FUN),
        .src_a   (ex.SRC_A),
        .src_b   (ex.SRC_B),
        .result  (alu_result)
    );

    // All three sub-functions are evaluated every cycle, independent of ALU_FUN.
    always_comb begin
        out_next        = '0;
        out_next.result = alu_result;
        out_next.jal    = ex.PC + ex.J_IMM;
        out_next.jalr   = (ex.RS1 + ex.I_IMM) & JALR_MASK;
        out_next.branch = ex.PC + ex.B_IMM;
        out_next.br_eq  = ex.RS1 == ex.RS2;
        out_next.br_lt  = $signed(ex.RS1) < $signed(ex.RS2);
        out_next.br_ltu = ex.RS1 < ex.RS2;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_q <= '0;
        end else if (ex.EN) begin
            out_q <= out_next;
        end
    end

    assign ex.RESULT = out_q.result;
    assign ex.JAL    = out_q.jal;
    assign ex.JALR   = out_q.jalr;
    assign ex.BRANCH = out_q.branch;
    assign ex.BR_EQ  = out_q.br_eq;
    assign ex.BR_LT  = out_q.br_lt;
    assign ex.BR_LTU = out_q.br_ltu;

endmodule

// File: tb/tb_otter_exec_unit.sv
// Scoreboard bench for otter_exec_unit: stimulus pushes expected register
// contents, a monitor pops and compares one entry after each rising edge.
module tb_otter_exec_unit;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] jal;
        logic [31:0] jalr;
        logic [31:0] branch;
        logic        eq;
        logic        lt;
        logic        ltu;
    } exp_t;

    logic CLK;
    logic RST;

    otter_exec_unit_if bus ();

    otter_exec_unit dut (
        .CLK (CLK),
        .RST (RST),
        .ex  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sbq[$];
    exp_t mdl;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference semantics written from the instruction definitions directly.
    function automatic exp_t ref_model(logic [3:0] fun, logic [31:0] a, logic [31:0] b,
                                       logic [31:0] rs1, logic [31:0] rs2, logic [31:0] pc,
                                       logic [31:0] iimm, logic [31:0] jimm, logic [31:0] bimm);
        exp_t        e;
        int unsigned sh;
        logic [31:0] fill;
        sh   = b % 32;
        fill = 32'hFFFF_FFFF;
        e    = '0;
        case (fun)
            4'b0000: e.result = a + b;
            4'b1000: e.result = a - b;
            4'b0001: e.result = a << sh;
            4'b0010: e.result = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'b0011: e.result = (a < b) ? 32'd1 : 32'd0;
            4'b0100: e.result = a ^ b;
            4'b0101: e.result = a >> sh;
            4'b1101: e.result = (a >> sh) | (a[31] ? ~(fill >> sh) : 32'd0);
            4'b0110: e.result = a | b;
            4'b0111: e.result = a & b;
            4'b1001: e.result = a;
            default: e.result = 32'd0;
        endcase
        e.jal    = pc + jimm;
        e.jalr   = rs1 + iimm;
        e.jalr[0] = 1'b0;
        e.branch = pc + bimm;
        e.eq     = (rs1 == rs2);
        e.ltu    = (rs1 < rs2);
        e.lt     = ((rs1 ^ 32'h8000_0000) < (rs2 ^ 32'h8000_0000));
        return e;
    endfunction

    task automatic drive(input logic en, input logic [3:0] fun, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] iimm,
                         input logic [31:0] jimm, input logic [31:0] bimm);
        @(negedge CLK);
        bus.EN      = en;
        bus.ALU_FUN = fun;
        bus.SRC_A   = a;
        bus.SRC_B   = b;
        bus.RS1     = rs1;
        bus.RS2     = rs2;
        bus.PC      = pc;
        bus.I_IMM   = iimm;
        bus.J_IMM   = jimm;
        bus.B_IMM   = bimm;
        if (en) mdl = ref_model(fun, a, b, rs1, rs2, pc, iimm, jimm, bimm);
        sbq.push_back(mdl);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_RESULT"}, bus.RESULT, 32'd0);
        chk({tag, "_JAL"},    bus.JAL,    32'd0);
        chk({tag, "_JALR"},   bus.JALR,   32'd0);
        chk({tag, "_BRANCH"}, bus.BRANCH, 32'd0);
        chk({tag, "_FLAGS"},  {29'd0, bus.BR_EQ, bus.BR_LT, bus.BR_LTU}, 32'd0);
    endtask

    always @(posedge CLK) begin
        #1;
        if (RST && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("RESULT", bus.RESULT, e.result);
            chk("JAL",    bus.JAL,    e.jal);
            chk("JALR",   bus.JALR,   e.jalr);
            chk("BRANCH", bus.BRANCH, e.branch);
            chk("BR_EQ",  {31'd0, bus.BR_EQ},  {31'd0, e.eq});
            chk("BR_LT",  {31'd0, bus.BR_LT},  {31'd0, e.lt});
            chk("BR_LTU", {31'd0, bus.BR_LTU}, {31'd0, e.ltu});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b, r1, r2;
        RST = 1'b0;
        mdl = '0;
        bus.EN = 1'b0; bus.ALU_FUN = '0; bus.SRC_A = '0; bus.SRC_B = '0;
        bus.RS1 = '0; bus.RS2 = '0; bus.PC = '0;
        bus.I_IMM = '0; bus.J_IMM = '0; bus.B_IMM = '0;
        repeat (2) @(posedge CLK);
        #1 check_zero("rst_init");
        @(negedge CLK);
        RST = 1'b1;

        // Directed ALU, compare and address cases
        drive(1, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'd0, 32'hFFFF_FFF8, 32'h20);
        drive(1, 4'b1000, 32'd0, 32'd1, 32'h1234, 32'h1234, 32'hFFFF_FFFC, 32'd0, 32'd4, 32'd8);
        drive(1, 4'b1101, 32'h8000_0000, 32'h24, 32'h203, 32'h5, 32'h100, 32'd0, 32'hFFFF_FFF8, 32'h20);
        drive(1, 4'b0101, 32'h8000_0000, 32'h24, 32'h7, 32'h8000_0000, 32'h40, 32'h1, 32'h10, 32'h4);
        drive(1, 4'b0001, 32'd1, 32'd31, 32'h8000_0000, 32'h7, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        drive(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'h8, 32'h3, 32'h4, 32'h4);
        drive(1, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h20, 32'h8, 32'h3, 32'h4, 32'h4);
        drive(1, 4'b1001, 32'hABCD_E000, 32'h5555, 32'h1, 32'h2, 32'h8, 32'h3, 32'h4, 32'h4);
        drive(1, 4'b1111, 32'h1234_5678, 32'h9, 32'h3, 32'h2, 32'h8, 32'h3, 32'h4, 32'h4);
        drive(1, 4'b0110, 32'hF0F0_0000, 32'h0F0F, 32'h3, 32'h3, 32'h18, 32'h6, 32'h8, 32'h8);

        // Stall: changing inputs with EN low must not disturb the register
        drive(0, 4'b0000, 32'd9, 32'd9, 32'h11, 32'h22, 32'h300, 32'h1, 32'h2, 32'h3);
        drive(0, 4'b1000, 32'd3, 32'd8, 32'h99, 32'h99, 32'h400, 32'h5, 32'h6, 32'h7);
        drive(0, 4'b0111, 32'hFF, 32'h0F, 32'h0, 32'hFFFF_FFFF, 32'h500, 32'h9, 32'hA, 32'hB);
        drive(1, 4'b0111, 32'hFF, 32'h0F, 32'h0, 32'hFFFF_FFFF, 32'h500, 32'h9, 32'hA, 32'hB);

        // Mid-stream asynchronous reset with nonzero outputs
        drive(1, 4'b0100, 32'hDEAD_BEEF, 32'h1, 32'h10, 32'h1, 32'h1000, 32'h11, 32'h20, 32'h30);
        @(posedge CLK);
        #3 RST = 1'b0;
        #1 check_zero("rst_async");
        mdl    = '0;
        bus.EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check_zero("rst_hold");
        @(negedge CLK);
        RST = 1'b1;
        drive(1, 4'b0000, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Randomized traffic mixing edge operands and equal register pairs
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 16);
                1: a = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                2: a = 32'h8000_0000 ^ $urandom_range(0, 3);
                default: a = $urandom;
            endcase
            b  = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 40);
            r1 = ($urandom_range(0, 2) == 0) ? a : $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : (($urandom_range(0, 1) != 0) ? b : $urandom);
            drive($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), a, b, r1, r2,
                  $urandom, $urandom, $urandom, $urandom);
        end

        repeat (3) @(negedge CLK);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
